// File: rtl/trigger_combiner_pkg.sv
// Shared definitions for the N-channel trigger combiner: mode codes, FSM
// encoding and the popcount used by the coincidence condition.
package trigger_combiner_pkg;

  localparam logic [1:0] MODE_OR  = 2'd0;
  localparam logic [1:0] MODE_AND = 2'd1;
  localparam logic [1:0] MODE_MAJ = 2'd2;
  localparam logic [1:0] MODE_OFF = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FIRE    = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // Wide enough to count all 16 channels of the largest configuration.
  localparam int POP_W = 5;

  function automatic logic [POP_W-1:0] popcount(input logic [15:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {{(POP_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/trigger_combiner_n_coinc_latch.sv
// One trigger channel: registered input, rising-edge detect and a window
// counter whose non-zero value is the channel's coincidence latch.
module coinc_latch
  import trigger_combiner_pkg::*;
#(
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_trig,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [WIN_W-1:0] i_win,
  output logic             o_latch
);

  logic             r_in;
  logic             r_prev;
  logic [WIN_W-1:0] r_cnt;
  logic             w_rise;
  logic [WIN_W-1:0] w_load;

  assign w_rise = r_in & ~r_prev;
  assign w_load = (i_win == '0) ? WIN_W'(1) : i_win;

  // Edge tracking continues through clears so a held level cannot re-trigger.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in   <= 1'b0;
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_in   <= i_trig;
      r_prev <= r_in;
      if (i_clear || !i_enable) begin
        r_cnt <= '0;
      end else if (w_rise) begin
        r_cnt <= w_load;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - WIN_W'(1);
      end
    end
  end

  assign o_latch = (r_cnt != '0);

endmodule

// File: rtl/trigger_combiner_n.sv
// N-channel trigger combiner: per-channel coincidence latches, OR/AND/majority
// condition, prescaler, output pulse and holdoff FSM, saturating counters.
module trigger_combiner_n
  import trigger_combiner_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int WIN_W      = 8,
  parameter int PRESCALE_W = 16,
  parameter int HOLDOFF_W  = 16,
  parameter int WIDTH_W    = 8,
  parameter int CNT_W      = 32
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [N_CH-1:0]           TRIG_IN,
  input  logic [N_CH-1:0]           ENABLE_MASK,
  input  logic [1:0]                MODE,
  input  logic [$clog2(N_CH+1)-1:0] MAJORITY_M,
  input  logic [WIN_W-1:0]          COINC_WINDOW,
  input  logic [PRESCALE_W-1:0]     PRESCALE,
  input  logic [HOLDOFF_W-1:0]      HOLDOFF,
  input  logic [WIDTH_W-1:0]        OUT_WIDTH,
  output logic                      TRIGGER_OUT,
  output logic [N_CH-1:0]           TRIGGER_PATTERN,
  output logic                      BUSY,
  output logic [CNT_W-1:0]          CANDIDATE_COUNT,
  output logic [CNT_W-1:0]          ACCEPT_COUNT,
  output state_t                    o_dbg_state
);

  localparam int TMR_W = (WIDTH_W > HOLDOFF_W) ? WIDTH_W : HOLDOFF_W;

  state_t                r_state, w_state_nxt;
  logic [TMR_W-1:0]      r_tmr, w_tmr_nxt;
  logic [PRESCALE_W-1:0] r_presc, w_presc_nxt;
  logic                  r_trig_out, w_trig_out_nxt;
  logic [N_CH-1:0]       r_pattern, w_pattern_nxt;
  logic [CNT_W-1:0]      r_cand, r_acc;
  logic                  w_candidate, w_accept, w_clear, w_cond;
  logic [N_CH-1:0]       w_latch, w_lvec;
  logic [POP_W-1:0]      w_pop, w_maj_m;
  logic [TMR_W-1:0]      w_width_m1;

  // Latches are held clear while dead and wiped by every candidate.
  assign w_clear = (r_state != ST_IDLE) || w_candidate;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    coinc_latch #(.WIN_W(WIN_W)) u_latch (
      .clk      (CLK),
      .rst_n    (RESET),
      .i_trig   (TRIG_IN[g]),
      .i_enable (ENABLE_MASK[g]),
      .i_clear  (w_clear),
      .i_win    (COINC_WINDOW),
      .o_latch  (w_latch[g])
    );
  end

  assign w_lvec     = w_latch & ENABLE_MASK;
  assign w_pop      = popcount(16'(w_lvec));
  assign w_maj_m    = (MAJORITY_M == '0) ? POP_W'(1) : POP_W'(MAJORITY_M);
  assign w_width_m1 = (OUT_WIDTH == '0) ? '0 : TMR_W'(OUT_WIDTH) - TMR_W'(1);

  always_comb begin
    w_cond = 1'b0;
    case (MODE)
      MODE_OR:  w_cond = (w_pop != '0);
      MODE_AND: w_cond = (ENABLE_MASK != '0) && (w_lvec == ENABLE_MASK);
      MODE_MAJ: w_cond = (w_pop >= w_maj_m);
      default:  w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tmr_nxt      = r_tmr;
    w_presc_nxt    = r_presc;
    w_trig_out_nxt = r_trig_out;
    w_pattern_nxt  = r_pattern;
    w_candidate    = 1'b0;
    w_accept       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cond) begin
          w_candidate = 1'b1;
          if (r_presc == PRESCALE) begin
            w_presc_nxt    = '0;
            w_accept       = 1'b1;
            w_pattern_nxt  = w_lvec;
            w_trig_out_nxt = 1'b1;
            w_tmr_nxt      = w_width_m1;
            w_state_nxt    = ST_FIRE;
          end else begin
            w_presc_nxt = r_presc + PRESCALE_W'(1);
          end
        end
      end
      ST_FIRE: begin
        if (r_tmr == '0) begin
          w_trig_out_nxt = 1'b0;
          if (HOLDOFF == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_HOLDOFF;
            w_tmr_nxt   = TMR_W'(HOLDOFF) - TMR_W'(1);
          end
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (r_tmr == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_tmr      <= '0;
      r_presc    <= '0;
      r_trig_out <= 1'b0;
      r_pattern  <= '0;
      r_cand     <= '0;
      r_acc      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmr      <= w_tmr_nxt;
      r_presc    <= w_presc_nxt;
      r_trig_out <= w_trig_out_nxt;
      r_pattern  <= w_pattern_nxt;
      if (w_candidate && (r_cand != '1)) r_cand <= r_cand + CNT_W'(1);
      if (w_accept && (r_acc != '1))     r_acc  <= r_acc + CNT_W'(1);
    end
  end

  assign TRIGGER_OUT     = r_trig_out;
  assign TRIGGER_PATTERN = r_pattern;
  assign BUSY            = (r_state != ST_IDLE);
  assign CANDIDATE_COUNT = r_cand;
  assign ACCEPT_COUNT    = r_acc;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_trigger_combiner_n.sv
// Directed-vector bench for trigger_combiner_n (N_CH=4): coincidence modes,
// prescale, holdoff masking, reset mid-pulse and never-fire configurations.
module tb_trigger_combiner_n;
  import trigger_combiner_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  trig_in, en_mask;
  logic [1:0]  mode;
  logic [2:0]  maj_m;
  logic [7:0]  win, out_width;
  logic [15:0] presc, holdoff;
  logic        trig_out, busy;
  logic [3:0]  pattern;
  logic [31:0] cand_cnt, acc_cnt;
  state_t      dbg_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trigger_combiner_n dut (
    .CLK             (clk),
    .RESET           (rst_n),
    .TRIG_IN         (trig_in),
    .ENABLE_MASK     (en_mask),
    .MODE            (mode),
    .MAJORITY_M      (maj_m),
    .COINC_WINDOW    (win),
    .PRESCALE        (presc),
    .HOLDOFF         (holdoff),
    .OUT_WIDTH       (out_width),
    .TRIGGER_OUT     (trig_out),
    .TRIGGER_PATTERN (pattern),
    .BUSY            (busy),
    .CANDIDATE_COUNT (cand_cnt),
    .ACCEPT_COUNT    (acc_cnt),
    .o_dbg_state     (dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [3:0] mask, input logic [2:0] mm,
                         input logic [7:0] w, input logic [15:0] p, input logic [15:0] h,
                         input logic [7:0] ow);
    mode = m; en_mask = mask; maj_m = mm; win = w; presc = p; holdoff = h; out_width = ow;
  endtask

  // seq[i] is on TRIG_IN when edge i samples it; bit i of oh/bh is seen after edge i.
  task automatic run_seq(input logic [31:0][3:0] seq, output logic [63:0] oh, output logic [63:0] bh);
    oh = '0;
    bh = '0;
    for (int i = 0; i < 64; i++) begin
      trig_in = (i < 32) ? seq[i] : 4'b0000;
      tick();
      oh[i] = trig_out;
      bh[i] = busy;
    end
  endtask

  task automatic test_reset();
    trig_in = '0;
    set_cfg(MODE_OR, 4'b0001, 3'd1, 8'd5, 16'd0, 16'd10, 8'd3);
    rst_n = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({trig_out, busy, pattern, cand_cnt, acc_cnt} !== 70'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got out=%b busy=%b pat=%b cand=%0d acc=%0d, want all 0",
               trig_out, busy, pattern, cand_cnt, acc_cnt);
    end
    n_vec++;
    if (dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_or();
    logic [31:0][3:0] seq;
    logic [63:0] oh, bh;
    seq = '0;
    seq[0] = 4'b0001;
    seq[1] = 4'b0001;
    set_cfg(MODE_OR, 4'b0001, 3'd1, 8'd5, 16'd0, 16'd10, 8'd3);
    run_seq(seq, oh, bh);
    n_vec++;
    if (oh !== 64'h1C) begin
      n_err++;
      $display("FAIL or_pulse: got %h want %h", oh, 64'h1C);
    end
    n_vec++;
    if (bh !== 64'h7FFC) begin
      n_err++;
      $display("FAIL or_busy: got %h want %h", bh, 64'h7FFC);
    end
    n_vec++;
    if ({pattern, cand_cnt, acc_cnt} !== {4'b0001, 32'd1, 32'd1}) begin
      n_err++;
      $display("FAIL or_status: got pat=%b cand=%0d acc=%0d want 0001/1/1", pattern, cand_cnt, acc_cnt);
    end
  endtask

  task automatic test_and();
    logic [31:0][3:0] seq;
    logic [63:0] oh, bh;
    set_cfg(MODE_AND, 4'b0011, 3'd1, 8'd4, 16'd0, 16'd0, 8'd1);
    seq = '0;
    seq[0] = 4'b0001;
    seq[3] = 4'b0010;
    run_seq(seq, oh, bh);
    n_vec++;
    if ({oh, bh} !== {64'h20, 64'h20}) begin
      n_err++;
      $display("FAIL and_inside_window: got out=%h busy=%h want 20/20", oh, bh);
    end
    n_vec++;
    if ({pattern, cand_cnt, acc_cnt} !== {4'b0011, 32'd2, 32'd2}) begin
      n_err++;
      $display("FAIL and_status: got pat=%b cand=%0d acc=%0d want 0011/2/2", pattern, cand_cnt, acc_cnt);
    end
    seq = '0;
    seq[0] = 4'b0001;
    seq[4] = 4'b0010;
    run_seq(seq, oh, bh);
    n_vec++;
    if ({oh, cand_cnt} !== {64'h0, 32'd2}) begin
      n_err++;
      $display("FAIL and_outside_window: got out=%h cand=%0d want 0/2", oh, cand_cnt);
    end
  endtask

  task automatic test_majority();
    logic [31:0][3:0] seq;
    logic [63:0] oh, bh;
    set_cfg(MODE_MAJ, 4'b1111, 3'd3, 8'd8, 16'd0, 16'd0, 8'd1);
    seq = '0;
    seq[0] = 4'b0101;
    seq[2] = 4'b1000;
    run_seq(seq, oh, bh);
    n_vec++;
    if (oh !== 64'h10) begin
      n_err++;
      $display("FAIL maj_three: got %h want %h", oh, 64'h10);
    end
    n_vec++;
    if ({pattern, cand_cnt, acc_cnt} !== {4'b1101, 32'd3, 32'd3}) begin
      n_err++;
      $display("FAIL maj_status: got pat=%b cand=%0d acc=%0d want 1101/3/3", pattern, cand_cnt, acc_cnt);
    end
    seq = '0;
    seq[0] = 4'b0101;
    run_seq(seq, oh, bh);
    n_vec++;
    if ({oh, cand_cnt} !== {64'h0, 32'd3}) begin
      n_err++;
      $display("FAIL maj_two: got out=%h cand=%0d want 0/3", oh, cand_cnt);
    end
  endtask

  task automatic test_prescale();
    logic [31:0][3:0] seq;
    logic [63:0] oh, bh, exp;
    logic [63:0] exp_q[$];
    set_cfg(MODE_OR, 4'b0001, 3'd1, 8'd2, 16'd3, 16'd0, 8'd1);
    for (int p = 0; p < 8; p++) exp_q.push_back((p == 3 || p == 7) ? 64'h4 : 64'h0);
    seq = '0;
    seq[0] = 4'b0001;
    for (int p = 0; p < 8; p++) begin
      run_seq(seq, oh, bh);
      exp = exp_q.pop_front();
      n_vec++;
      if (oh !== exp) begin
        n_err++;
        $display("FAIL prescale_pulse%0d: got %h want %h", p, oh, exp);
      end
    end
    n_vec++;
    if ({cand_cnt, acc_cnt} !== {32'd11, 32'd5}) begin
      n_err++;
      $display("FAIL prescale_counts: got cand=%0d acc=%0d want 11/5", cand_cnt, acc_cnt);
    end
  endtask

  task automatic test_holdoff();
    logic [31:0][3:0] seq;
    logic [63:0] oh, bh;
    set_cfg(MODE_OR, 4'b0011, 3'd1, 8'd4, 16'd0, 16'd20, 8'd2);
    seq = '0;
    for (int i = 6; i < 32; i++) seq[i] = 4'b0001;
    seq[0]  = 4'b0010;
    seq[5]  = 4'b0010;
    seq[8]  = 4'b0011;
    seq[26] = 4'b0011;
    run_seq(seq, oh, bh);
    n_vec++;
    if (oh !== 64'h0000_0000_3000_000C) begin
      n_err++;
      $display("FAIL holdoff_pulses: got %h want %h", oh, 64'h0000_0000_3000_000C);
    end
    n_vec++;
    if (bh !== 64'h0003_FFFF_F0FF_FFFC) begin
      n_err++;
      $display("FAIL holdoff_busy: got %h want %h", bh, 64'h0003_FFFF_F0FF_FFFC);
    end
    n_vec++;
    if ({pattern, cand_cnt, acc_cnt} !== {4'b0010, 32'd13, 32'd7}) begin
      n_err++;
      $display("FAIL holdoff_status: got pat=%b cand=%0d acc=%0d want 0010/13/7", pattern, cand_cnt, acc_cnt);
    end
  endtask

  task automatic test_reset_mid_fire();
    set_cfg(MODE_OR, 4'b0001, 3'd1, 8'd5, 16'd0, 16'd5, 8'd10);
    trig_in = 4'b0001;
    tick();
    trig_in = 4'b0000;
    repeat (5) tick();
    n_vec++;
    if ({trig_out, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL midfire_active: got out=%b busy=%b want 1/1", trig_out, busy);
    end
    rst_n = 1'b0;
    tick();
    n_vec++;
    if ({trig_out, busy, pattern, cand_cnt, acc_cnt} !== 70'd0 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL midfire_reset: got out=%b busy=%b pat=%b cand=%0d acc=%0d st=%0d want all 0",
               trig_out, busy, pattern, cand_cnt, acc_cnt, dbg_state);
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_never_fire();
    logic [31:0][3:0] seq;
    logic [63:0] oh, bh;
    seq = '0;
    seq[0] = 4'b1111;
    set_cfg(MODE_OFF, 4'b1111, 3'd1, 8'd4, 16'd0, 16'd0, 8'd1);
    run_seq(seq, oh, bh);
    n_vec++;
    if ({oh, cand_cnt} !== {64'h0, 32'd0}) begin
      n_err++;
      $display("FAIL mode_off: got out=%h cand=%0d want 0/0", oh, cand_cnt);
    end
    set_cfg(MODE_AND, 4'b0000, 3'd1, 8'd4, 16'd0, 16'd0, 8'd1);
    run_seq(seq, oh, bh);
    n_vec++;
    if ({oh, cand_cnt} !== {64'h0, 32'd0}) begin
      n_err++;
      $display("FAIL and_mask_zero: got out=%h cand=%0d want 0/0", oh, cand_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_or();
    test_and();
    test_majority();
    test_prescale();
    test_holdoff();
    test_reset_mid_fire();
    test_never_fire();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trigger_combiner_n.md
Name: trigger_combiner_n

Overview:
Parametrised N-channel trigger combiner, successor to the fixed four-input trigger handler. Takes N trigger lines (edge, TOT, staged-filter, external, extra detector channels) and applies per-channel rising-edge capture with a programmable coincidence window. Combines them in OR / AND / M-of-N majority mode, then applies prescaling, output pulse width and post-trigger holdoff. Sits between the per-channel trigger generators and the readout/capture logic in the CLK_FAST domain.

Parameters:
N_CH, 4, number of trigger input channels (2..16)
WIN_W, 8, width of coincidence-window length
PRESCALE_W, 16, width of prescale divisor
HOLDOFF_W, 16, width of holdoff length
WIDTH_W, 8, width of output pulse length
CNT_W, 32, width of candidate/accepted counters

Ports:
CLK  in  1  fast clock
RESET  in  1  synchronous, active-low reset
TRIG_IN  in  N_CH  raw trigger lines, synchronous to CLK
ENABLE_MASK  in  N_CH  1 = channel participates
MODE  in  2  0 OR, 1 AND, 2 MAJORITY, 3 disabled
MAJORITY_M  in  $clog2(N_CH+1)  required channel count in MAJORITY mode
COINC_WINDOW  in  WIN_W  latch lifetime in cycles
PRESCALE  in  PRESCALE_W  accept 1 of every PRESCALE+1 candidates
HOLDOFF  in  HOLDOFF_W  dead cycles after pulse
OUT_WIDTH  in  WIDTH_W  TRIGGER_OUT high cycles
TRIGGER_OUT  out  1  combined trigger pulse
TRIGGER_PATTERN  out  N_CH  latched channel vector at last accept
BUSY  out  1  high in FIRE or HOLDOFF
CANDIDATE_COUNT  out  CNT_W  coincidences found (pre-prescale)
ACCEPT_COUNT  out  CNT_W  triggers issued

Behaviour:
- Reset (RESET=0 at a CLK edge): all outputs 0, latches and window counters cleared, prescale counter 0, state IDLE, previous-input regs 0. Reset mid-FIRE drops TRIGGER_OUT the next edge.
- Edge capture: per channel, rise = TRIG_IN & ~prev. Rise on an enabled channel in IDLE loads that channel's window counter with max(COINC_WINDOW,1) and sets its latch on the next edge. Latch stays set exactly max(COINC_WINDOW,1) cycles. A re-rise while latched reloads the counter. Disabled channels never latch.
- Condition, evaluated on latch vector L masked by ENABLE_MASK:
  - OR: popcount(L)>=1.
  - AND: ENABLE_MASK!=0 and L==ENABLE_MASK.
  - MAJORITY: popcount(L)>=max(MAJORITY_M,1); M>N_CH never fires.
  - Mode 3: never fires.
- FSM states IDLE, FIRE, HOLDOFF:
  - IDLE with condition true: a candidate. CANDIDATE_COUNT++, all latches cleared.
    - If prescale counter == PRESCALE: counter->0, ACCEPT_COUNT++, TRIGGER_PATTERN<=L, TRIGGER_OUT<=1, go FIRE.
    - Else counter++, stay IDLE.
  - FIRE: TRIGGER_OUT high for max(OUT_WIDTH,1) cycles, then HOLDOFF; with HOLDOFF=0, go directly to IDLE.
  - HOLDOFF: HOLDOFF cycles, then IDLE.
  - In FIRE/HOLDOFF, rises are ignored and latches are held clear. prev keeps tracking, so a level held high across the dead time does not re-trigger.
- Latency: input sampled high at edge k, latch set at k+1, TRIGGER_OUT high after edge k+2 (2 cycles).
- Simultaneous rises on several channels in one cycle count as coincident.
- Counters saturate at all-ones.
- Config inputs are used live. Software changes them only while BUSY=0; prescale counter is not reset by PRESCALE changes.

Decomposition:
- Package trigger_combiner_pkg: MODE_OR/MODE_AND/MODE_MAJ/MODE_OFF constants, FSM state encoding (ST_IDLE, ST_FIRE, ST_HOLDOFF), popcount function.
- Sub-module coinc_latch: one instance per channel, generate loop. Contains edge detect, window counter, latch output, clear and enable inputs.
- Top holds condition logic, FSM, prescaler and counters.

Test Plan:
- OR, mask=4'b0001, WIN=5, OUT_WIDTH=3, HOLDOFF=10, PRESCALE=0; single rise ch0 at cycle 10 -> TRIGGER_OUT high cycles 12-14, BUSY high through 24, PATTERN=0001, both counts=1.
- AND, mask=4'b0011, WIN=4; ch0 rise at t, ch1 rise at t+3 -> fires at t+5. Repeat with ch1 at t+4 -> no trigger, CANDIDATE_COUNT unchanged.
- MAJORITY M=3, all enabled, WIN=8; ch0,ch2 rise together, ch3 at +2 -> one trigger, PATTERN=1101. Only two channels -> none.
- PRESCALE=3, OR mode, 8 well-separated ch0 pulses -> CANDIDATE_COUNT=8, ACCEPT_COUNT=2, triggers on the 4th and 8th pulses.
- During HOLDOFF=20, ch1 pulses and ch0 held high -> no trigger, no counter change. Latches are clear on return to IDLE; a new ch1 rise fires normally.
- RESET asserted low mid-FIRE (OUT_WIDTH=10, at pulse cycle 4) -> TRIGGER_OUT, BUSY and counters 0 next edge. Mode 3 and mask=0 in AND mode never fire.
